muldiv_unit: RTL

- Parametrised, iterative multiply/divide unit; the multi-cycle companion to the single-cycle datapath ALU, generalised to WIDTH bits.
- Execute stage issues an operation with a one-cycle start pulse, stalls while busy is high, and captures res when done pulses.
- Shift-add multiply and restoring divide, one bit per cycle. There is no combinational multiplier or divider array.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Issue/complete handshake between the execute stage (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             div_zero;

    modport master (
        output start, op, signed_op, a, b,
        input  busy, done, res, div_zero
    );

    modport slave (
        input  start, op, signed_op, a, b,
        output busy, done, res, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide, one bit per cycle.
// Define MULDIV_SIGNED_EN to honour signed_op (two's-complement operands).
module muldiv_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CW     = $clog2(WIDTH);
    localparam logic [1:0]  OP_MUL = 2'b00;
    localparam logic [1:0]  OP_MULH = 2'b01;
    localparam logic [1:0]  OP_DIV = 2'b10;
    localparam logic [1:0]  OP_REM = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic               busy_q, done_q, busy_nxt, done_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   hi, lo, opnd;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   res_q;
    logic               div_zero_q;
    logic               accept, dz;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   hi_step, lo_step, quo, rem, res_sel;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept = bus.start && (state != RUN);
    assign dz     = bus.op[1] && (bus.b == '0);

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.res      = res_q;
    assign bus.div_zero = div_zero_q;

`ifdef MULDIV_SIGNED_EN
    logic neg_start, neg_q;

    // Magnitudes at issue; the sign of the result is remembered in neg_q.
    always_comb begin
        a_mag     = bus.a;
        b_mag     = bus.b;
        neg_start = 1'b0;
        if (bus.signed_op) begin
            if (bus.a[WIDTH-1]) a_mag = -bus.a;
            if (bus.b[WIDTH-1]) b_mag = -bus.b;
            neg_start = (bus.op == OP_REM) ? bus.a[WIDTH-1]
                                           : (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        end
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = bus.signed_op;
    assign a_mag = bus.a;
    assign b_mag = bus.b;
`endif

    // One iteration of either algorithm on {hi, lo}.
    always_comb begin
        mul_sum   = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        if (op_q[1]) begin
            hi_step = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_step = {lo[WIDTH-2:0], div_ge};
        end else begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Result selection, with sign correction when enabled.
    always_comb begin
        prod_fix = {hi_step, lo_step};
        quo      = lo_step;
        rem      = hi_step;
`ifdef MULDIV_SIGNED_EN
        if (neg_q) begin
            prod_fix = -{hi_step, lo_step};
            quo      = -lo_step;
            rem      = -hi_step;
        end
`endif
        case (op_q)
            OP_MUL:  res_sel = prod_fix[WIDTH-1:0];
            OP_MULH: res_sel = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV:  res_sel = quo;
            default: res_sel = rem;
        endcase
    end

    // State register, with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) state_nxt = dz ? DONE : RUN;
                else           state_nxt = IDLE;
            end
            RUN:     if (cnt == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode, registered alongside the state.
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (state_nxt == RUN)  busy_nxt = 1'b1;
        if (state_nxt == DONE) done_nxt = 1'b1;
    end

    // Datapath: operand latch at issue, iterate in RUN, write res on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
            cnt        <= '0;
            res_q      <= '0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else if (accept) begin
            op_q       <= bus.op;
            hi         <= '0;
            cnt        <= CW'(WIDTH - 1);
            div_zero_q <= dz;
`ifdef MULDIV_SIGNED_EN
            neg_q      <= neg_start;
`endif
            if (bus.op[1]) begin
                lo   <= a_mag;
                opnd <= b_mag;
            end else begin
                lo   <= b_mag;
                opnd <= a_mag;
            end
            if (dz) res_q <= bus.op[0] ? bus.a : '1;
        end else if (state == RUN) begin
            hi  <= hi_step;
            lo  <= lo_step;
            cnt <= cnt - CW'(1);
            if (cnt == '0) res_q <= res_sel;
        end
    end
endmodule
